// File: rtl/mux_sel_pipe.sv
// Registered N:1 operand selector with a valid/ready output stage.
// The index comes from either the direct select input or an internal round-robin pointer.
module mux_sel_pipe #(
  parameter int WIDTH  = 12,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // One extra bit so the compare still works when NUM_IN == 2**SEL_W.
  localparam logic [SEL_W:0]   LP_NUM_IN = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] w_inputs [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign w_inputs[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [SEL_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_err;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [SEL_W-1:0] w_idx;
  logic             w_idx_ok;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_rr_next;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_idx      = mode ? r_rr_ptr : sel;
  assign w_idx_ok   = {1'b0, w_idx} < LP_NUM_IN;
  assign w_rr_next  = (r_rr_ptr == LP_LAST) ? '0 : r_rr_ptr + 1'b1;

  // Out-of-range indices match no input and fall through to zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_idx == SEL_W'(k)) w_sel_data = w_inputs[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_data  <= w_idx_ok ? w_sel_data : '0;
        r_out_sel   <= w_idx;
        r_out_err   <= !mode && !w_idx_ok;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && mode) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;

endmodule
